// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver, scan-code set 2 decoder and event FIFO
//
// Purpose:
//   Receives PS/2 frames from a keyboard, strips the E0/F0 prefixes into
//   {code, ext, brk} key events, tracks six modifier keys and queues the
//   events in a first-word-fall-through FIFO for the consuming logic.
//
// Ports:
//   CLK, RST        system clock, asynchronous active-high reset
//   PS2_CLK1        keyboard clock line (asynchronous to CLK)
//   PS2_DATA1       keyboard data line (asynchronous to CLK)
//   EV_VALID        FIFO holds at least one event
//   EV_READY        consumer takes the head event (pop on EV_VALID & EV_READY)
//   EV_CODE         head event scan code, prefixes stripped
//   EV_EXT          head event was preceded by E0
//   EV_BREAK        head event is a release (F0 seen)
//   EV_MODS         {ralt,lalt,rctrl,lctrl,rshift,lshift} after the head event
//   MODS            live modifier state, same bit order
//   ERR_PARITY      one-cycle pulse on a parity error
//   ERR_FRAME       one-cycle pulse on a stop-bit error or inter-bit timeout
//   OVERFLOW        sticky, set when an event was dropped on a full FIFO
//
// Optional feature macro:
//   PS2_TYPEMATIC_FILTER_EN  suppress repeated makes of the same key until
//                            that key is released (one make per press)

module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK1,
    input  logic       PS2_DATA1,
    output logic       EV_VALID,
    input  logic       EV_READY,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic [5:0] EV_MODS,
    output logic [5:0] MODS,
    output logic       ERR_PARITY,
    output logic       ERR_FRAME,
    output logic       OVERFLOW
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    // Lines idle high, so the synchronizers and filter start high: a
    // reset never fabricates a falling edge.
    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic       filt_clk;
    logic [7:0] filt_cnt;
    logic       strobe;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK1;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DATA1;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive cycles
    // at the new level. strobe is high in the first cycle the filtered
    // clock is low, which is when the data bit is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    strobe   <= ~clk_s2;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          byte_valid;
    logic          err_par_c;
    logic          err_frm_c;

    assign timeout = (state != S_IDLE) && !strobe && (to_cnt == TO_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_valid = 1'b0;
        err_par_c  = 1'b0;
        err_frm_c  = 1'b0;
        if (timeout) begin
            state_nxt = S_IDLE;
            err_frm_c = 1'b1;
        end else if (strobe) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    if (!dat_s2)
                        err_frm_c = 1'b1;
                    else if (par_ok)
                        byte_valid = 1'b1;
                    else
                        err_par_c = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (state == S_IDLE || strobe)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (strobe) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_ok <= (^shift) ^ dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    // Error pulses are registered so the outputs are glitch-free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_PARITY <= 1'b0;
            ERR_FRAME  <= 1'b0;
        end else begin
            ERR_PARITY <= err_par_c;
            ERR_FRAME  <= err_frm_c;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder and modifier tracking
    // ------------------------------------------------------------------
    logic        ext, brk;
    logic [5:0]  mods_nxt;
    logic        push_allow;
    logic        push;
    logic [15:0] push_entry;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       lm_valid;
    logic [8:0] lm_key;
`endif

    always_comb begin
        mods_nxt = MODS;
        case ({ext, shift})
            9'h012:  mods_nxt[0] = ~brk;
            9'h059:  mods_nxt[1] = ~brk;
            9'h014:  mods_nxt[2] = ~brk;
            9'h114:  mods_nxt[3] = ~brk;
            9'h011:  mods_nxt[4] = ~brk;
            9'h111:  mods_nxt[5] = ~brk;
            default: ;
        endcase
    end

    always_comb begin
        push_allow = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        // Auto-repeat of the key last pressed produces no new event.
        if (!brk && lm_valid && (lm_key == {ext, shift}))
            push_allow = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            MODS       <= '0;
            push       <= 1'b0;
            push_entry <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            lm_valid   <= 1'b0;
            lm_key     <= '0;
`endif
        end else begin
            push <= 1'b0;
            if (err_par_c || err_frm_c) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    MODS       <= mods_nxt;
                    push       <= push_allow;
                    push_entry <= {shift, ext, brk, mods_nxt};
                    ext        <= 1'b0;
                    brk        <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!brk) begin
                        lm_valid <= 1'b1;
                        lm_key   <= {ext, shift};
                    end else if (lm_key == {ext, shift}) begin
                        lm_valid <= 1'b0;
                    end
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          pop, wr_en;
    logic [15:0]   head;

    assign EV_VALID = (count != '0);
    assign pop      = EV_VALID && EV_READY;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign wr_en    = push && ((count != FULL_CNT) || pop);

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wptr] <= push_entry;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !wr_en)
                OVERFLOW <= 1'b1;
        end
    end

    // Outputs read zero while empty so nothing stale is ever presented.
    assign head     = mem[rptr];
    assign EV_CODE  = EV_VALID ? head[15:8] : 8'h00;
    assign EV_EXT   = EV_VALID ? head[7]    : 1'b0;
    assign EV_BREAK = EV_VALID ? head[6]    : 1'b0;
    assign EV_MODS  = EV_VALID ? head[5:0]  : 6'h00;

endmodule
